// File: rtl/aac_ola_pkg.sv
// rtl/aac_ola_pkg.sv - shared types, sizing helpers and saturating add for the overlap-add engine
package aac_ola_pkg;

    localparam int DEF_WORD_W   = 16;
    localparam int DEF_LANES    = 4;
    localparam int DEF_HALF_WIN = 512;

    typedef enum logic {
        PH_ADD   = 1'b0,
        PH_STORE = 1'b1
    } phase_t;

    function automatic int beats_of(input int half_win, input int lanes);
        return half_win / lanes;
    endfunction

    function automatic int cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    localparam int DEF_BEATS = beats_of(DEF_HALF_WIN, DEF_LANES);
    localparam int DEF_CNT_W = cnt_width(DEF_BEATS);

    function automatic logic [DEF_WORD_W-1:0] sat_add(
        input logic signed [DEF_WORD_W-1:0] a,
        input logic signed [DEF_WORD_W-1:0] b,
        input logic                         sat
    );
        logic signed [DEF_WORD_W:0] s;
        s = {a[DEF_WORD_W-1], a} + {b[DEF_WORD_W-1], b};
        if (sat && (s[DEF_WORD_W] != s[DEF_WORD_W-1]))
            return s[DEF_WORD_W] ? {1'b1, {(DEF_WORD_W-1){1'b0}}}
                                 : {1'b0, {(DEF_WORD_W-1){1'b1}}};
        return s[DEF_WORD_W-1:0];
    endfunction

endpackage

// File: rtl/aac_overlap_add_if.sv
// rtl/aac_overlap_add_if.sv - input/output beat streams and frame status of the overlap-add engine
interface aac_overlap_add_if #(
    parameter int WORD_W = 16,
    parameter int LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*WORD_W-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*WORD_W-1:0]   out_data;
    logic                      frame_done;
    logic                      first_frame;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, frame_done, first_frame
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, frame_done, first_frame
    );
endinterface

// File: rtl/aac_ola_lane_add.sv
// rtl/aac_ola_lane_add.sv - one signed lane adder with optional clamp to the WORD_W range
module aac_ola_lane_add #(
    parameter int WORD_W = 16,
    parameter int SAT    = 1
) (
    input  logic signed [WORD_W-1:0] i_a,
    input  logic signed [WORD_W-1:0] i_b,
    output logic        [WORD_W-1:0] o_sum
);
    localparam logic [WORD_W-1:0] MAX_VAL = {1'b0, {(WORD_W-1){1'b1}}};
    localparam logic [WORD_W-1:0] MIN_VAL = {1'b1, {(WORD_W-1){1'b0}}};

    logic signed [WORD_W:0] w_wide;
    logic                   w_ovf;

    assign w_wide = {i_a[WORD_W-1], i_a} + {i_b[WORD_W-1], i_b};
    // Overflow iff the extra sign bit disagrees with the WORD_W-bit sign.
    assign w_ovf  = w_wide[WORD_W] ^ w_wide[WORD_W-1];

    always_comb begin
        o_sum = w_wide[WORD_W-1:0];
        if ((SAT != 0) && w_ovf)
            o_sum = w_wide[WORD_W] ? MIN_VAL : MAX_VAL;
    end
endmodule

// File: rtl/aac_overlap_add.sv
// rtl/aac_overlap_add.sv - IMDCT overlap-add: sums first half with stored second half, emits PCM beats
module aac_overlap_add
    import aac_ola_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int LANES    = DEF_LANES,
    parameter int HALF_WIN = DEF_HALF_WIN,
    parameter int SAT      = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    aac_overlap_add_if.slave   bus
);
    localparam int BEATS  = beats_of(HALF_WIN, LANES);
    localparam int CNT_W  = cnt_width(BEATS);
    localparam int BUS_W  = LANES * WORD_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    phase_t             r_phase;
    phase_t             w_phase_next;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_prev_valid;
    logic               r_out_valid;
    logic [BUS_W-1:0]   r_out_data;
    logic               r_frame_done;
    logic [BUS_W-1:0]   r_ovl [BEATS];

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic [BUS_W-1:0]   w_ovl_rd;
    logic [BUS_W-1:0]   w_sum;

    assign w_last   = (r_beat_cnt == LAST_BEAT);
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_ovl_rd = r_ovl[r_beat_cnt];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_phase <= PH_ADD;
        else
            r_phase <= w_phase_next;
    end

    always_comb begin
        w_phase_next = r_phase;
        w_in_ready   = 1'b0;
        if (flush) begin
            w_phase_next = PH_ADD;
        end else begin
            case (r_phase)
                PH_ADD: begin
                    w_in_ready = !r_out_valid || bus.out_ready;
                    if (bus.in_valid && w_in_ready && w_last)
                        w_phase_next = PH_STORE;
                end
                PH_STORE: begin
                    w_in_ready = 1'b1;
                    if (bus.in_valid && w_last)
                        w_phase_next = PH_ADD;
                end
                default: w_phase_next = PH_ADD;
            endcase
        end
    end

    // First frame after reset/flush passes the raw first half through.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [WORD_W-1:0] w_a;
        logic signed [WORD_W-1:0] w_b;

        assign w_a = bus.in_data[g*WORD_W +: WORD_W];
        assign w_b = r_prev_valid ? w_ovl_rd[g*WORD_W +: WORD_W] : '0;

        aac_ola_lane_add #(
            .WORD_W (WORD_W),
            .SAT    (SAT)
        ) u_lane_add (
            .i_a   (w_a),
            .i_b   (w_b),
            .o_sum (w_sum[g*WORD_W +: WORD_W])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat_cnt   <= '0;
            r_prev_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (flush) begin
                r_beat_cnt   <= '0;
                r_prev_valid <= 1'b0;
                r_out_valid  <= 1'b0;
            end else begin
                if (r_out_valid && bus.out_ready)
                    r_out_valid <= 1'b0;
                if (w_accept) begin
                    r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                    if (r_phase == PH_ADD) begin
                        r_out_data  <= w_sum;
                        r_out_valid <= 1'b1;
                    end else if (w_last) begin
                        r_prev_valid <= 1'b1;
                        r_frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    // History is deliberately not reset; prev_valid masks stale contents.
    always_ff @(posedge clock) begin
        if (w_accept && (r_phase == PH_STORE))
            r_ovl[r_beat_cnt] <= bus.in_data;
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.frame_done  = r_frame_done;
    assign bus.first_frame = !r_prev_valid;

endmodule

// File: tb/tb_aac_overlap_add.sv
// tb/tb_aac_overlap_add.sv - directed cycle-table bench for aac_overlap_add (SAT=1 and SAT=0 instances)
module tb_aac_overlap_add;
    localparam int WORD_W   = 16;
    localparam int LANES    = 4;
    localparam int HALF_WIN = 8;
    localparam int BUS_W    = WORD_W * LANES;
    localparam int NV       = 26;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    aac_overlap_add_if #(.WORD_W(WORD_W), .LANES(LANES)) bus_s ();
    aac_overlap_add_if #(.WORD_W(WORD_W), .LANES(LANES)) bus_w ();

    assign bus_w.in_valid  = bus_s.in_valid;
    assign bus_w.in_data   = bus_s.in_data;
    assign bus_w.out_ready = bus_s.out_ready;

    aac_overlap_add #(.WORD_W(WORD_W), .LANES(LANES), .HALF_WIN(HALF_WIN), .SAT(1)) u_dut_sat (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus_s)
    );

    aac_overlap_add #(.WORD_W(WORD_W), .LANES(LANES), .HALF_WIN(HALF_WIN), .SAT(0)) u_dut_wrap (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus_w)
    );

    typedef struct {
        bit iv;  int din; int dstep; bit ordy; bit fl;
        bit e_ir; bit e_ov; bit chk_d; int e_out; int e_step;
        bit e_fd; bit e_ff; bit chk_w; int e_wrap;
    } vec_t;

    vec_t vt [NV];
    int checks = 0;
    int errors = 0;

    function automatic logic [BUS_W-1:0] pack(input int base, input int step);
        logic [BUS_W-1:0] v;
        int w;
        for (int i = 0; i < LANES; i++) begin
            w = base + i * step;
            v[i*WORD_W +: WORD_W] = w[WORD_W-1:0];
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        //            iv din    st ordy fl  ir ov cd out    est fd ff cw wrap
        vt[0]  = '{1, 100,    0, 1, 0,  1, 0, 0, 0,      0, 0, 1, 0, 0};
        vt[1]  = '{1, 100,    0, 1, 0,  1, 1, 1, 100,    0, 0, 1, 0, 0};
        vt[2]  = '{1, 100,    0, 1, 0,  1, 1, 1, 100,    0, 0, 1, 0, 0};
        vt[3]  = '{1, 100,    0, 1, 0,  1, 0, 0, 0,      0, 0, 1, 0, 0};
        vt[4]  = '{1, 23,     0, 1, 0,  1, 0, 0, 0,      0, 1, 0, 0, 0};
        vt[5]  = '{1, 23,     1, 1, 0,  1, 1, 1, 123,    0, 0, 0, 0, 0};
        vt[6]  = '{1, 32767,  0, 1, 0,  1, 1, 1, 123,    1, 0, 0, 0, 0};
        vt[7]  = '{1, -32768, 0, 1, 0,  1, 0, 0, 0,      0, 0, 0, 0, 0};
        vt[8]  = '{1, 10,     0, 1, 0,  1, 0, 0, 0,      0, 1, 0, 0, 0};
        vt[9]  = '{1, -1,     0, 1, 0,  1, 1, 1, 32767,  0, 0, 0, 1, -32759};
        vt[10] = '{1, 50,     0, 0, 0,  1, 1, 1, -32768, 0, 0, 0, 1, 32767};
        vt[11] = '{1, 60,     0, 0, 0,  1, 1, 1, -32768, 0, 0, 0, 0, 0};
        vt[12] = '{1, 1,      0, 0, 0,  0, 1, 1, -32768, 0, 1, 0, 0, 0};
        vt[13] = '{1, 1,      0, 0, 0,  0, 1, 1, -32768, 0, 0, 0, 0, 0};
        vt[14] = '{1, 1,      0, 0, 0,  0, 1, 1, -32768, 0, 0, 0, 0, 0};
        vt[15] = '{1, 1,      0, 0, 0,  0, 1, 1, -32768, 0, 0, 0, 0, 0};
        vt[16] = '{1, 1,      0, 0, 0,  0, 1, 1, -32768, 0, 0, 0, 0, 0};
        vt[17] = '{1, 1,      0, 1, 0,  1, 1, 1, -32768, 0, 0, 0, 0, 0};
        vt[18] = '{1, 2,      0, 1, 0,  1, 1, 1, 51,     0, 0, 0, 0, 0};
        vt[19] = '{1, 9,      0, 0, 0,  1, 1, 1, 62,     0, 0, 0, 0, 0};
        vt[20] = '{1, 9,      0, 0, 1,  0, 1, 1, 62,     0, 0, 0, 0, 0};
        vt[21] = '{1, 7,      0, 1, 0,  1, 0, 0, 0,      0, 0, 1, 0, 0};
        vt[22] = '{1, 7,      0, 1, 0,  1, 1, 1, 7,      0, 0, 1, 0, 0};
        vt[23] = '{1, 7,      0, 1, 0,  1, 1, 1, 7,      0, 0, 1, 0, 0};
        vt[24] = '{1, 7,      0, 1, 0,  1, 0, 0, 0,      0, 0, 1, 0, 0};
        vt[25] = '{0, 0,      0, 1, 0,  1, 0, 0, 0,      0, 1, 0, 0, 0};

        bus_s.in_valid  = 1'b0;
        bus_s.in_data   = '0;
        bus_s.out_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid",   BUS_W'(bus_s.out_valid),   BUS_W'(0));
        chk("rst_out_data",    bus_s.out_data,            '0);
        chk("rst_frame_done",  BUS_W'(bus_s.frame_done),  BUS_W'(0));
        chk("rst_first_frame", BUS_W'(bus_s.first_frame), BUS_W'(1));
        chk("rst_in_ready",    BUS_W'(bus_s.in_ready),    BUS_W'(1));
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(posedge clock);
            #1;
            bus_s.in_valid  = vt[k].iv;
            bus_s.in_data   = pack(vt[k].din, vt[k].dstep);
            bus_s.out_ready = vt[k].ordy;
            flush           = vt[k].fl;
            #1;
            chk($sformatf("v%0d_in_ready", k),    BUS_W'(bus_s.in_ready),    BUS_W'(vt[k].e_ir));
            chk($sformatf("v%0d_out_valid", k),   BUS_W'(bus_s.out_valid),   BUS_W'(vt[k].e_ov));
            chk($sformatf("v%0d_frame_done", k),  BUS_W'(bus_s.frame_done),  BUS_W'(vt[k].e_fd));
            chk($sformatf("v%0d_first_frame", k), BUS_W'(bus_s.first_frame), BUS_W'(vt[k].e_ff));
            if (vt[k].chk_d)
                chk($sformatf("v%0d_out_data", k), bus_s.out_data, pack(vt[k].e_out, vt[k].e_step));
            if (vt[k].chk_w)
                chk($sformatf("v%0d_wrap_data", k), bus_w.out_data, pack(vt[k].e_wrap, 0));
        end

        // Pending output beat, then asynchronous reset between clock edges.
        @(posedge clock);
        #1;
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = pack(5, 0);
        bus_s.out_ready = 1'b0;
        @(posedge clock);
        #1;
        bus_s.in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", BUS_W'(bus_s.out_valid), BUS_W'(1));
        chk("pre_rst_out_data",  bus_s.out_data,          pack(12, 0));
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid",   BUS_W'(bus_s.out_valid),   BUS_W'(0));
        chk("async_rst_first_frame", BUS_W'(bus_s.first_frame), BUS_W'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus_s.out_ready = 1'b1;

        for (int b = 0; b < 4; b++) begin
            @(posedge clock);
            #1;
            bus_s.in_valid = 1'b1;
            bus_s.in_data  = pack(100, 0);
            #1;
            chk($sformatf("r%0d_in_ready", b),    BUS_W'(bus_s.in_ready),    BUS_W'(1));
            chk($sformatf("r%0d_first_frame", b), BUS_W'(bus_s.first_frame), BUS_W'(1));
            if (b == 1 || b == 2) begin
                chk($sformatf("r%0d_out_valid", b), BUS_W'(bus_s.out_valid), BUS_W'(1));
                chk($sformatf("r%0d_out_data", b),  bus_s.out_data,          pack(100, 0));
            end
        end
        @(posedge clock);
        #1;
        bus_s.in_valid = 1'b0;
        #1;
        chk("r_end_frame_done",  BUS_W'(bus_s.frame_done),  BUS_W'(1));
        chk("r_end_first_frame", BUS_W'(bus_s.first_frame), BUS_W'(0));
        chk("r_end_out_valid",   BUS_W'(bus_s.out_valid),   BUS_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
